iterative_divider: RTL and testbench

- Multi-cycle restoring divider for the MIPS DIV/DIVU path. It is the subtract-side counterpart of the datapath adder.
- Takes a dividend and a divisor and produces a quotient (LO) and a remainder (HI).
- Produces one quotient bit per clock, using a start/busy/done handshake toward the control unit.
- Sits beside the ALU. The control unit stalls on BUSY, then writes the HI/LO registers on DONE.

---
 rtl/iterative_divider_pkg.sv | 19 +
 rtl/iterative_divider_div_step.sv | 27 ++
 rtl/iterative_divider.sv | 131 +++++++++++++
 tb/tb_iterative_divider.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/iterative_divider_pkg.sv
// Shared definitions for the restoring divider: FSM encoding, default width
// and the width of the step counter.
package iterative_divider_pkg;

  localparam int DATA_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int CNT_W = cnt_width(DATA_SIZE);

endpackage

// File: rtl/iterative_divider_div_step.sv
// One restoring-division step, purely combinational: shift in a dividend bit,
// trial-subtract the divisor with a borrow bit, keep the difference if non-negative.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] divisor,
  input  logic         in_bit,
  output logic [W-1:0] rem_nx,
  output logic         q_bit
);

  logic [W:0]   shifted;
  logic [W+1:0] diff;
  logic [W:0]   sel;
  logic         unused_sel_msb;

  assign shifted = {rem, in_bit};
  assign diff    = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit   = ~diff[W+1];

  // Whichever value survives is below the divisor, so its top bit is always 0.
  assign sel            = q_bit ? diff[W:0] : shifted;
  assign rem_nx         = sel[W-1:0];
  assign unused_sel_msb = sel[W];

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring DIV/DIVU: one quotient bit per clock, Data_Size+1 cycles
// from START to DONE (1 for divide-by-zero); START is ignored while BUSY.
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int Data_Size = DATA_SIZE
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 SIGNED_OP,
  input  logic [Data_Size-1:0] INPUT_A,
  input  logic [Data_Size-1:0] INPUT_B,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 DIV_BY_ZERO,
  output logic [Data_Size-1:0] OUTPUT_Q,
  output logic [Data_Size-1:0] OUTPUT_R
);

  localparam int W  = Data_Size;
  localparam int CW = cnt_width(Data_Size);

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   rem;
  logic [W-1:0]   quo;
  logic [W-1:0]   dvs;
  logic           q_neg;
  logic           r_neg;
  logic           dbz;

  logic           accept;
  logic           b_zero;
  logic           a_neg;
  logic           b_neg;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W-1:0]   rem_nx;
  logic           q_bit;

  assign a_neg  = SIGNED_OP & INPUT_A[W-1];
  assign b_neg  = SIGNED_OP & INPUT_B[W-1];
  assign a_mag  = a_neg ? -INPUT_A : INPUT_A;
  assign b_mag  = b_neg ? -INPUT_B : INPUT_B;
  assign b_zero = (INPUT_B == '0);

  // The DONE cycle is already IDLE but still counts as busy.
  assign accept = (state == IDLE) & START & ~DONE;
  assign BUSY   = (state != IDLE) | DONE;

  div_step #(.W(W)) u_step (
    .rem     (rem),
    .divisor (dvs),
    .in_bit  (quo[W-1]),
    .rem_nx  (rem_nx),
    .q_bit   (q_bit)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = b_zero ? FIX : CALC;
      CALC:    if (cnt == '0) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dbz         <= 1'b0;
      DONE        <= 1'b0;
      DIV_BY_ZERO <= 1'b0;
      OUTPUT_Q    <= '0;
      OUTPUT_R    <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rem <= '0;
            cnt <= CW'(Data_Size - 1);
            dbz <= b_zero;
            // On divide-by-zero the raw dividend rides in quo to become the remainder.
            if (b_zero) begin
              quo   <= INPUT_A;
              dvs   <= '0;
              q_neg <= 1'b0;
              r_neg <= 1'b0;
            end else begin
              quo   <= a_mag;
              dvs   <= b_mag;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= {quo[W-2:0], q_bit};
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          DONE        <= 1'b1;
          DIV_BY_ZERO <= dbz;
          if (dbz) begin
            OUTPUT_Q <= '1;
            OUTPUT_R <= quo;
          end else begin
            OUTPUT_Q <= q_neg ? -quo : quo;
            OUTPUT_R <= r_neg ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: a driver issues operations and queues
// arithmetic expectations; a monitor pops and compares on every DONE.
module tb_iterative_divider;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic         SIGNED_OP;
  logic [W-1:0] INPUT_A;
  logic [W-1:0] INPUT_B;
  logic         BUSY;
  logic         DONE;
  logic         DIV_BY_ZERO;
  logic [W-1:0] OUTPUT_Q;
  logic [W-1:0] OUTPUT_R;

  iterative_divider #(.Data_Size(W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .SIGNED_OP   (SIGNED_OP),
    .INPUT_A     (INPUT_A),
    .INPUT_B     (INPUT_B),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .DIV_BY_ZERO (DIV_BY_ZERO),
    .OUTPUT_Q    (OUTPUT_Q),
    .OUTPUT_R    (OUTPUT_R)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic, truncating division as MIPS defines it.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input int c);
    exp_t   e;
    longint sa, sb, qq, rr;
    e.cyc = c;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
      return e;
    end
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'b0, a};
      sb = {32'b0, b};
    end
    qq    = sa / sb;
    rr    = sa % sb;
    e.q   = qq[W-1:0];
    e.r   = rr[W-1:0];
    e.dbz = 1'b0;
    return e;
  endfunction

  always @(negedge CLK) begin
    if (!RST && DONE) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: DONE=1 at cycle %0d, expected no completion", cyc);
      end else begin
        e = exp_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("quotient", OUTPUT_Q, e.q);
        check("remainder", OUTPUT_R, e.r);
        check("div_by_zero", DIV_BY_ZERO, e.dbz);
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input bit repulse);
    logic [W-1:0] hq, hr;
    bit           seen;
    int           lat;
    seen = 0;
    lat  = (b == '0) ? 1 : W + 1;
    @(negedge CLK);
    START     = 1'b1;
    SIGNED_OP = s;
    INPUT_A   = a;
    INPUT_B   = b;
    exp_q.push_back(model(a, b, s, cyc + 1 + lat));
    hq = OUTPUT_Q;
    hr = OUTPUT_R;
    for (int k = 1; k <= 80; k++) begin
      @(negedge CLK);
      START = 1'b0;
      if (repulse && (k == 5 || k == 33 || k == 34)) begin
        START     = 1'b1;
        SIGNED_OP = 1'b1;
        INPUT_A   = $urandom;
        INPUT_B   = $urandom_range(1, 9);
      end
      check("busy_during_op", BUSY, 1'b1);
      if (DONE) begin
        seen = 1;
        break;
      end
      check("q_held_during_calc", OUTPUT_Q, hq);
      check("r_held_during_calc", OUTPUT_R, hr);
    end
    check("done_seen", seen, 1'b1);
    @(negedge CLK);
    START = 1'b0;
    check("busy_after_done", BUSY, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST       = 1'b1;
    START     = 1'b0;
    SIGNED_OP = 1'b0;
    INPUT_A   = '0;
    INPUT_B   = '0;
    repeat (3) @(negedge CLK);
    check("reset_busy", BUSY, 1'b0);
    check("reset_done", DONE, 1'b0);
    check("reset_dbz", DIV_BY_ZERO, 1'b0);
    check("reset_q", OUTPUT_Q, '0);
    check("reset_r", OUTPUT_R, '0);
    RST = 1'b0;

    run_op(32'd100, 32'd7, 1'b0, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    run_op(32'd5, 32'd0, 1'b0, 0);
    run_op(32'd5, 32'd0, 1'b1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'd100, 32'd7, 1'b0, 1);

    // Abort mid-operation: everything clears at once and the operation never completes.
    @(negedge CLK);
    START     = 1'b1;
    SIGNED_OP = 1'b0;
    INPUT_A   = 32'd100;
    INPUT_B   = 32'd7;
    @(negedge CLK);
    START = 1'b0;
    repeat (9) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("abort_busy", BUSY, 1'b0);
    check("abort_done", DONE, 1'b0);
    check("abort_dbz", DIV_BY_ZERO, 1'b0);
    check("abort_q", OUTPUT_Q, '0);
    check("abort_r", OUTPUT_R, '0);
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      check("no_done_after_abort", DONE, 1'b0);
    end
    run_op(32'hFFFF_FFFF, 32'h10, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] a, b;
      logic         s;
      int           mode;
      s    = 1'($urandom_range(0, 1));
      a    = $urandom;
      mode = $urandom_range(0, 9);
      case (mode)
        0:       b = '0;
        1:       b = $urandom_range(1, 15);
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3:       b = a;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(a, b, s, 0);
    end

    repeat (5) @(negedge CLK);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
